// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter shared types and constants.
// Imported by the arbiter, its round-robin picker and its interface users.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] GRANT_INST = 2'b01;
  localparam logic [1:0] GRANT_DATA = 2'b10;

  localparam int MEM_LATENCY_DEF = 2;

  typedef struct packed {
    logic        src_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Fetch, LSU and memory-port signals of unified_mem_arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface unified_mem_arbiter_if;

  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic        i_valid;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_valid;
  logic [31:0] d_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_dout,
    output i_ready, i_valid, i_rdata,
    output d_ready, d_valid, d_rdata,
    output mem_addr, mem_din,
    output mem_read, mem_write
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_dout,
    input  i_ready, i_valid, i_rdata,
    input  d_ready, d_valid, d_rdata,
    input  mem_addr, mem_din,
    input  mem_read, mem_write
  );

endinterface

// File: rtl/unified_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin picker for fetch vs data.
// On a tie the side that did not win last time gets the grant.
module rr_arbiter2
  import unified_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       req_i,
  input  logic       req_d,
  output logic [1:0] grant
);

  logic [1:0] last_grant;

  always_comb begin
    grant = '0;
    if (en) begin
      unique case (1'b1)
        (req_i && req_d):
          grant = (last_grant == GRANT_INST) ?
                  GRANT_DATA : GRANT_INST;
        (req_i && !req_d): grant = GRANT_INST;
        (!req_i && req_d): grant = GRANT_DATA;
        default:           grant = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= GRANT_INST;
    end else if (grant != '0) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported word memory between fetch and LSU.
// One request in flight: accept, MEM_LATENCY busy cycles, one valid pulse.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DEF,
  parameter int CNT_W       = $clog2(MEM_LATENCY) + 1
) (
  input logic                  clk,
  input logic                  reset,
  unified_mem_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(MEM_LATENCY - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  mem_req_t         req_q;
  mem_req_t         req_nxt;
  logic [1:0]       grant;
  logic             idle;
  logic             busy;
  logic             last_cyc;
  logic             i_valid_q;
  logic             d_valid_q;
  logic [31:0]      i_rdata_q;
  logic [31:0]      d_rdata_q;
  logic [31:0]      resp;

  assign idle     = (state == IDLE);
  assign busy     = (state == BUSY);
  assign last_cyc = busy && (cnt == '0);

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (idle),
    .req_i (bus.i_req),
    .req_d (bus.d_req),
    .grant (grant)
  );

  always_comb begin
    req_nxt = req_q;
    if (grant == GRANT_DATA) begin
      req_nxt.src_d = 1'b1;
      req_nxt.we    = bus.d_we;
      req_nxt.addr  = bus.d_addr;
      req_nxt.wdata = bus.d_wdata;
    end else begin
      req_nxt.src_d = 1'b0;
      req_nxt.we    = 1'b0;
      req_nxt.addr  = bus.i_addr;
    end
  end

  // Writes complete with a zero data word.
  assign resp = req_q.we ? 32'd0 : bus.mem_dout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_q     <= '0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant != '0) begin
            req_q <= req_nxt;
            cnt   <= CNT_INIT;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= DONE;
            if (req_q.src_d) begin
              d_rdata_q <= resp;
              d_valid_q <= 1'b1;
            end else begin
              i_rdata_q <= resp;
              i_valid_q <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.i_ready   = grant[0];
  assign bus.d_ready   = grant[1];
  assign bus.i_valid   = i_valid_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_addr  = req_q.addr;
  assign bus.mem_din   = req_q.wdata;
  assign bus.mem_read  = busy && !req_q.we;
  assign bus.mem_write = last_cyc && req_q.we;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_unified_mem_arbiter;

  localparam int L = 2;

  logic clk;
  logic reset;
  int   checks;
  int   fails;

  unified_mem_arbiter_if bus ();
  unified_mem_arbiter_if bus1 ();

  unified_mem_arbiter #(.MEM_LATENCY(L)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  unified_mem_arbiter #(.MEM_LATENCY(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [3:0] i);
    return (i == 4'd4) ? 32'hDEADBEEF :
           (32'hC0DE_5A50 ^ {28'd0, i});
  endfunction

  // Memory stub: 16 words, combinational read, posedge write.
  logic [31:0] mem [0:15];
  logic [15:0] wr = '0;
  logic [3:0]  midx;
  assign midx = bus.mem_addr[5:2];
  assign bus.mem_dout = wr[midx] ? mem[midx] : init_word(midx);
  always @(posedge clk) begin
    if (bus.mem_write) begin
      mem[midx] <= bus.mem_din;
      wr[midx]  <= 1'b1;
    end
  end

  assign bus1.mem_dout = ~bus1.mem_addr;

  logic [31:0] shadow [0:15];

  task automatic clr();
    bus.i_req = 0; bus.i_addr = 0;
    bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0;
    bus1.i_req = 0; bus1.i_addr = 0;
    bus1.d_req = 0; bus1.d_we = 0;
    bus1.d_addr = 0; bus1.d_wdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr();
    reset = 0;
    @(negedge clk);
    reset = 1;
  endtask

  task automatic run_one(
    input bit sd, input bit we,
    input logic [31:0] a, input logic [31:0] wd,
    output int rdy_c, output int n_rd,
    output int n_wr, output int wr_c,
    output int val_c, output int n_val,
    output logic [31:0] rdata);
    rdy_c = -1; n_rd = 0; n_wr = 0; wr_c = -1;
    val_c = -1; n_val = 0; rdata = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rdy_c < 0) begin
        bus.i_req = !sd; bus.i_addr = a;
        bus.d_req = sd; bus.d_we = we;
        bus.d_addr = a; bus.d_wdata = wd;
      end else begin
        bus.i_req = 0; bus.d_req = 0;
        bus.i_addr = $urandom; bus.d_addr = $urandom;
        bus.d_wdata = $urandom; bus.d_we = 1'($urandom);
      end
      #1;
      if ((sd ? bus.d_ready : bus.i_ready) && rdy_c < 0)
        rdy_c = c;
      if (bus.mem_read) n_rd++;
      if (bus.mem_write) begin n_wr++; wr_c = c; end
      if (sd ? bus.d_valid : bus.i_valid) begin
        n_val++; val_c = c;
        rdata = sd ? bus.d_rdata : bus.i_rdata;
      end
    end
    clr();
  endtask

  task automatic test_reset();
    logic [5:0] f;
    @(negedge clk); #1;
    f = {bus.i_ready, bus.d_ready, bus.i_valid,
         bus.d_valid, bus.mem_read, bus.mem_write};
    checks++;
    if (f !== 6'b0) begin
      fails++; $display("FAIL reset_flags got %b exp 000000", f);
    end
    checks++;
    if ({bus.i_rdata, bus.d_rdata} !== 64'd0) begin
      fails++; $display("FAIL reset_rdata got %h %h exp 0",
                        bus.i_rdata, bus.d_rdata);
    end
    checks++;
    if ({bus.mem_addr, bus.mem_din} !== 64'd0) begin
      fails++; $display("FAIL reset_mem got %h %h exp 0",
                        bus.mem_addr, bus.mem_din);
    end
    reset = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      f = {bus.i_ready, bus.d_ready, bus.i_valid,
           bus.d_valid, bus.mem_read, bus.mem_write};
      checks++;
      if (f !== 6'b0) begin
        fails++; $display("FAIL idle_flags c=%0d got %b exp 0", c, f);
      end
    end
  endtask

  task automatic test_inst_read();
    int rc, nr, nw, wc, vc, nv;
    logic [31:0] d;
    run_one(0, 0, 32'h10, 0, rc, nr, nw, wc, vc, nv, d);
    checks++;
    if (rc !== 0 || nr !== L || nw !== 0) begin
      fails++;
      $display("FAIL iread_timing rdy=%0d rd=%0d wr=%0d exp 0/%0d/0",
               rc, nr, nw, L);
    end
    checks++;
    if (vc !== L + 1 || nv !== 1 || d !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL iread_resp vc=%0d nv=%0d d=%h exp %0d/1/deadbeef",
               vc, nv, d, L + 1);
    end
  endtask

  task automatic test_write_read();
    int rc, nr, nw, wc, vc, nv;
    logic [31:0] d;
    run_one(1, 1, 32'h20, 32'h12345678,
            rc, nr, nw, wc, vc, nv, d);
    shadow[8] = 32'h12345678;
    checks++;
    if (rc !== 0 || nw !== 1 || wc !== L || nr !== 0) begin
      fails++;
      $display("FAIL dwrite_strobe rdy=%0d nw=%0d wc=%0d nr=%0d exp 0/1/%0d/0",
               rc, nw, wc, nr, L);
    end
    checks++;
    if (vc !== L + 1 || nv !== 1 || d !== 32'd0) begin
      fails++;
      $display("FAIL dwrite_resp vc=%0d nv=%0d d=%h exp %0d/1/0",
               vc, nv, d, L + 1);
    end
    run_one(1, 0, 32'h20, 32'hFFFF_FFFF,
            rc, nr, nw, wc, vc, nv, d);
    checks++;
    if (nr !== L || nw !== 0 || vc !== L + 1 || nv !== 1 ||
        d !== 32'h12345678) begin
      fails++;
      $display("FAIL dread_back nr=%0d nw=%0d vc=%0d nv=%0d d=%h exp 12345678",
               nr, nw, vc, nv, d);
    end
  endtask

  task automatic test_contention();
    logic [31:0] ia, da, ea, ed;
    logic [1:0] er, ev;
    ia = 32'h00; da = 32'h30; ed = 0; ea = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      bus.i_req = 1; bus.i_addr = ia;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = da;
      #1;
      er = {c == 4, c == 0 || c == 8};
      ev = {c == 7, c == 3 || c == 11};
      checks++;
      if ({bus.i_ready, bus.d_ready} !== er) begin
        fails++; $display("FAIL rr_ready c=%0d got %b exp %b",
                          c, {bus.i_ready, bus.d_ready}, er);
      end
      checks++;
      if ({bus.i_valid, bus.d_valid} !== ev) begin
        fails++; $display("FAIL rr_valid c=%0d got %b exp %b",
                          c, {bus.i_valid, bus.d_valid}, ev);
      end
      if (ev != 2'b00) begin
        checks++;
        if ((ev[1] ? bus.i_rdata : bus.d_rdata) !== ed) begin
          fails++; $display("FAIL rr_data c=%0d got %h exp %h", c,
                            ev[1] ? bus.i_rdata : bus.d_rdata, ed);
        end
      end
      if (er[1]) begin ed = shadow[ia[5:2]]; ia += 4; end
      if (er[0]) begin ed = shadow[da[5:2]]; da += 4; end
      ea = ea + 0;
    end
    clr();
  endtask

  task automatic test_withdraw();
    int bad;
    bad = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.i_req = (c == 0); bus.i_addr = 32'h8;
      bus.d_req = (c == 1 || c == 2); bus.d_we = 1;
      bus.d_addr = 32'h3C; bus.d_wdata = $urandom;
      #1;
      checks++;
      if ({bus.i_ready, bus.mem_read} !== {c == 0, c == 1 || c == 2}) begin
        fails++; $display("FAIL wd_inst c=%0d got %b%b", c,
                          bus.i_ready, bus.mem_read);
      end
      if (bus.d_ready || bus.d_valid || bus.mem_write) bad++;
    end
    checks++;
    if (bad !== 0) begin
      fails++; $display("FAIL wd_data_access got %0d cycles exp 0", bad);
    end
    clr();
  endtask

  task automatic test_reset_mid_write();
    int rc, nr, nw, wc, vc, nv;
    logic [31:0] d;
    do_reset();
    @(negedge clk);
    bus.d_req = 1; bus.d_we = 1;
    bus.d_addr = 32'h2C; bus.d_wdata = 32'hA5A5_5A5A;
    #1;
    checks++;
    if (bus.d_ready !== 1'b1) begin
      fails++; $display("FAIL rst_accept got %b exp 1", bus.d_ready);
    end
    @(negedge clk);
    clr();
    @(negedge clk); #1;
    checks++;
    if (bus.mem_write !== 1'b1) begin
      fails++; $display("FAIL rst_pre_write got %b exp 1", bus.mem_write);
    end
    reset = 0;
    #1;
    checks++;
    if (bus.mem_write !== 1'b0) begin
      fails++; $display("FAIL rst_async_write got %b exp 0", bus.mem_write);
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.d_valid, bus.mem_write, bus.mem_read} !== 3'b0) begin
      fails++; $display("FAIL rst_quiet got %b exp 000",
                        {bus.d_valid, bus.mem_write, bus.mem_read});
    end
    reset = 1;
    run_one(0, 0, 32'h2C, 0, rc, nr, nw, wc, vc, nv, d);
    checks++;
    if (rc !== 0 || vc !== L + 1 || nv !== 1 || d !== shadow[11]) begin
      fails++;
      $display("FAIL rst_after rdy=%0d vc=%0d nv=%0d d=%h exp %h",
               rc, vc, nv, d, shadow[11]);
    end
  endtask

  task automatic test_latency1();
    logic [31:0] ia, pa;
    logic [2:0] e;
    ia = 32'h100; pa = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus1.i_req = 1; bus1.i_addr = ia;
      #1;
      e = {c % 3 == 0, c % 3 == 1, c % 3 == 2};
      checks++;
      if ({bus1.i_ready, bus1.mem_read, bus1.i_valid} !== e) begin
        fails++; $display("FAIL l1_flags c=%0d got %b exp %b", c,
                 {bus1.i_ready, bus1.mem_read, bus1.i_valid}, e);
      end
      if (e[1]) begin
        checks++;
        if (bus1.mem_addr !== pa) begin
          fails++; $display("FAIL l1_addr got %h exp %h",
                            bus1.mem_addr, pa);
        end
      end
      if (e[0]) begin
        checks++;
        if (bus1.i_rdata !== ~pa) begin
          fails++; $display("FAIL l1_data got %h exp %h",
                            bus1.i_rdata, ~pa);
        end
      end
      if (e[2]) begin pa = ia; ia += 4; end
    end
    clr();
  endtask

  task automatic test_random();
    bit ih, dh, dwe, act, t_d, t_we, last_d, gi, gd, busy;
    logic [31:0] ia, da, dwd, t_a, t_wd, t_dat, eir, edr;
    logic [5:0] ef, gf;
    int acc, next_acc;
    ih = 0; dh = 0; dwe = 0; act = 0; t_d = 0; t_we = 0;
    last_d = 0; ia = 0; da = 0; dwd = 0; t_a = 0; t_wd = 0;
    t_dat = 0; eir = 0; edr = 0; acc = 0; next_acc = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!ih && $urandom_range(2) == 0) begin
        ih = 1; ia = 32'($urandom_range(63));
      end else if (ih && $urandom_range(19) == 0) ih = 0;
      if (!dh && $urandom_range(2) == 0) begin
        dh = 1; da = 32'($urandom_range(63));
        dwe = 1'($urandom); dwd = $urandom;
      end else if (dh && $urandom_range(19) == 0) dh = 0;
      bus.i_req = ih; bus.i_addr = ih ? ia : $urandom;
      bus.d_req = dh; bus.d_we = dh ? dwe : 1'($urandom);
      bus.d_addr = dh ? da : $urandom;
      bus.d_wdata = dh ? dwd : $urandom;
      #1;
      gi = (c >= next_acc) && ih && (!dh || last_d);
      gd = (c >= next_acc) && dh && (!ih || !last_d);
      busy = act && c > acc && c <= acc + L;
      if (act && c == acc + L + 1) begin
        if (t_d) edr = t_dat; else eir = t_dat;
      end
      ef = {gi, gd, busy && !t_we, busy && t_we && c == acc + L,
            act && c == acc + L + 1 && !t_d,
            act && c == acc + L + 1 && t_d};
      gf = {bus.i_ready, bus.d_ready, bus.mem_read, bus.mem_write,
            bus.i_valid, bus.d_valid};
      checks++;
      if (gf !== ef) begin
        fails++; $display("FAIL rnd_flags c=%0d got %b exp %b", c, gf, ef);
      end
      checks++;
      if ({bus.i_rdata, bus.d_rdata} !== {eir, edr}) begin
        fails++; $display("FAIL rnd_rdata c=%0d got %h %h exp %h %h", c,
                          bus.i_rdata, bus.d_rdata, eir, edr);
      end
      if (busy) begin
        checks++;
        if (bus.mem_addr !== t_a || (t_we && bus.mem_din !== t_wd)) begin
          fails++; $display("FAIL rnd_port c=%0d got %h %h exp %h %h", c,
                            bus.mem_addr, bus.mem_din, t_a, t_wd);
        end
      end
      if (gi || gd) begin
        act = 1; acc = c; t_d = gd; t_we = gd && dwe;
        t_a = gd ? da : ia; t_wd = dwd;
        t_dat = t_we ? 32'd0 : shadow[t_a[5:2]];
        if (t_we) shadow[t_a[5:2]] = dwd;
        last_d = gd; next_acc = c + L + 2;
        if (gi) ih = 0; else dh = 0;
      end
    end
    clr();
  endtask

  initial begin
    checks = 0; fails = 0;
    reset = 0;
    clr();
    for (int i = 0; i < 16; i++) shadow[i] = init_word(4'(i));
    test_reset();
    test_inst_read();
    test_write_read();
    test_contention();
    test_withdraw();
    test_reset_mid_write();
    test_latency1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
